// File: rtl/vga_pkg.sv
// Shared VGA timing constants: default 640x480@60 mode, derived totals and
// sync polarity encodings.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter. count/sync_region/in_active
// describe the position after this clock edge so the top can register them.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync_region,
  output logic          in_active
);

  localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = SYNC_START + SYNC;

  logic [CW-1:0] count_q;

  assign wrap = enable && (count_q == CW'(TOTAL - 1));

  always_comb begin
    count = count_q;
    if (wrap)
      count = '0;
    else if (enable)
      count = count_q + CW'(1);
  end

  assign sync_region = (count >= CW'(SYNC_START)) && (count < CW'(SYNC_END));
  assign in_active   = (count < CW'(ACTIVE));

  always_ff @(posedge clk) begin
    if (!reset_n)
      count_q <= '0;
    else
      count_q <= count;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-latched coordinate
// scaling, line/frame pulses, sticky vblank interrupt and frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit H_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter bit V_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int CW         = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pixel_strobe,
  input  logic [1:0]    scale,
  input  logic          irq_ack,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_irq,
  output logic [15:0]   frame_count
);

  localparam logic [CW-1:0] Y_BLANK = CW'(V_ACTIVE - 1);

  logic [CW-1:0] h_next, v_next;
  logic          h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
  logic          frame_wrap, vblank_set;
  logic [1:0]    scale_q, scale_next;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h (
    .clk(clk), .reset_n(reset_n), .enable(pixel_strobe),
    .count(h_next), .wrap(h_wrap), .sync_region(h_sync), .in_active(h_act)
  );

  // h_wrap already includes the strobe, so v steps once per line.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v (
    .clk(clk), .reset_n(reset_n), .enable(h_wrap),
    .count(v_next), .wrap(v_wrap), .sync_region(v_sync), .in_active(v_act)
  );

  assign frame_wrap = h_wrap && v_wrap;
  assign vblank_set = h_wrap && (v_next == CW'(V_ACTIVE));
  assign scale_next = frame_wrap ? scale : scale_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scale_q     <= scale;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      active      <= 1'b1;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank_irq  <= 1'b0;
      frame_count <= '0;
    end else begin
      scale_q     <= scale_next;
      hsync       <= h_sync ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= v_sync ? V_SYNC_POL : ~V_SYNC_POL;
      active      <= h_act && v_act;
      x           <= h_act ? (h_next >> scale_next) : '0;
      y           <= v_act ? (v_next >> scale_next) : (Y_BLANK >> scale_next);
      line_start  <= h_wrap;
      frame_start <= frame_wrap;
      // A coincident ack loses so software never misses a new vblank.
      if (vblank_set)
        vblank_irq <= 1'b1;
      else if (irq_ack)
        vblank_irq <= 1'b0;
      if (frame_wrap)
        frame_count <= frame_count + 16'd1;
    end
  end

endmodule
